// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sizing helpers,
// default geometry and the byte-merge used by both write and bypass paths.
package regfile_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 32;

  // Widest datapath the byte-merge helper handles; callers size-cast in and out.
  localparam int unsigned MaxWidth = 256;
  localparam int unsigned MaxNb    = MaxWidth / 8;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

  // Byte-wise merge: bytes with strb set come from new_val, others keep old_val.
  function automatic logic [MaxWidth-1:0] merge(input logic [MaxWidth-1:0] old_val,
                                                input logic [MaxWidth-1:0] new_val,
                                                input logic [MaxNb-1:0]    strb);
    logic [MaxWidth-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(MaxNb); i++) begin
      if (strb[i]) begin
        res[i*8 +: 8] = new_val[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Parametrised N-input selector over a packed input bus. Any select value
// that does not name an input (sel_i >= N) yields all zeros, which the
// register file relies on for out-of-range reads.
module mux_n_to_1 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o
);

  // Compare-and-select per input; no match leaves the zero default.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, one
// byte-strobed synchronous write port, optional hardwired-zero entry 0,
// optional write-to-read bypass and a committed-state-only debug port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = DefaultWidth,
  parameter  int unsigned DEPTH    = DefaultDepth,
  parameter  int unsigned NUM_RD   = 2,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1,
  localparam int unsigned NB       = WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [NB-1:0]            wstrb,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]  rdata,
  input  logic [ADDR_W-1:0]        dbg_sel,
  output logic [WIDTH-1:0]         dbg_data
);

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] DepthCmp = DEPTH[ADDR_W:0];

  // WIDTH-sized wrapper around the package merge.
  function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old_val,
                                               input logic [WIDTH-1:0] new_val,
                                               input logic [NB-1:0]    strb);
    return WIDTH'(merge(MaxWidth'(old_val), MaxWidth'(new_val), MaxNb'(strb)));
  endfunction

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;

  logic waddr_in_range;
  logic waddr_is_zero;
  logic wr_ok;
  logic byp_en;

  // A write is dropped for out-of-range addresses and for the hardwired zero entry.
  assign waddr_in_range = ({1'b0, waddr} < DepthCmp);
  assign waddr_is_zero  = (waddr == '0);
  assign wr_ok          = we && waddr_in_range && !(ZERO_REG && waddr_is_zero);

  // Bypass is only live out of reset; reads during reset see cleared storage.
  assign byp_en = BYPASS && reset_n && wr_ok;

  // Next-state for storage: merge the strobed bytes into the addressed entry.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_ok && (waddr == ADDR_W'(i))) begin
        mem_d[i] = merge_w(mem_q[i], wdata, wstrb);
      end
    end
  end

  // Storage flops; reset clears every entry without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar e = 0; e < int'(DEPTH); e++) begin : g_flat
    assign mem_flat[e*WIDTH +: WIDTH] = mem_q[e];
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  stored;
    logic [WIDTH-1:0]  rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    mux_n_to_1 #(
      .WIDTH(WIDTH),
      .N    (DEPTH),
      .SEL_W(ADDR_W)
    ) u_rd_mux (
      .data_i(mem_flat),
      .sel_i (ra),
      .data_o(stored)
    );

    // Read priority: zero entry, then same-cycle bypass, then stored value.
    // Out-of-range addresses already come back as zero from the selector and
    // can never match an accepted write address.
    always_comb begin
      rd = stored;
      if (ZERO_REG && (ra == '0)) begin
        rd = '0;
      end else if (byp_en && (ra == waddr)) begin
        rd = merge_w(stored, wdata, wstrb);
      end
    end

    assign rdata[k*WIDTH +: WIDTH] = rd;
  end

  logic [WIDTH-1:0] dbg_stored;

  mux_n_to_1 #(
    .WIDTH(WIDTH),
    .N    (DEPTH),
    .SEL_W(ADDR_W)
  ) u_dbg_mux (
    .data_i(mem_flat),
    .sel_i (dbg_sel),
    .data_o(dbg_stored)
  );

  // Debug port shows committed state only, so it never takes the bypass.
  always_comb begin
    dbg_data = dbg_stored;
    if (ZERO_REG && (dbg_sel == '0)) begin
      dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance A (DEPTH=32, NUM_RD=3, bypass on) and
// instance B (DEPTH=24, NUM_RD=2, bypass off) share one stimulus stream.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [14:0] raddr;
  logic [4:0]  dbg_sel;
  logic [95:0] rdata_a;
  logic [31:0] dbg_a;
  logic [63:0] rdata_b;
  logic [31:0] dbg_b;

  regfile_mp #(
    .WIDTH(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr), .rdata(rdata_a), .dbg_sel(dbg_sel), .dbg_data(dbg_a)
  );

  regfile_mp #(
    .WIDTH(32), .DEPTH(24), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr[9:0]), .rdata(rdata_b), .dbg_sel(dbg_sel), .dbg_data(dbg_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  ra0, ra1, ra2, dbg;
    logic [31:0] e0, e1, e2, edbg;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] a0, a1, a2, adbg;
    bit          chk_b;
    logic [31:0] b0, b1, bdbg;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        tbl[13];
  logic [31:0] ma[32];
  logic [31:0] mb[24];
  int          checks   = 0;
  int          failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mmerge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // Reference read for instance A (is_b=0) or B (is_b=1) under current inputs.
  function automatic logic [31:0] model_rd(bit is_b, logic [4:0] a, bit byp);
    int          depth;
    logic [31:0] st;
    depth = is_b ? 24 : 32;
    if (int'(a) >= depth || a == 5'd0) return 32'h0;
    st = is_b ? mb[a] : ma[a];
    if (byp && reset_n === 1'b1 && we === 1'b1 && waddr == a) return mmerge(st, wdata, wstrb);
    return st;
  endfunction

  task automatic drive(input vec_t v);
    reset_n = v.rst;
    we      = v.we;
    waddr   = v.waddr;
    wdata   = v.wdata;
    wstrb   = v.wstrb;
    raddr   = {v.ra2, v.ra1, v.ra0};
    dbg_sel = v.dbg;
    if (!v.rst) begin
      for (int i = 0; i < 32; i++) ma[i] = 32'h0;
      for (int i = 0; i < 24; i++) mb[i] = 32'h0;
    end
  endtask

  // Advance through the rising edge (model commits with the DUT) to the next falling edge.
  task automatic commit_edge();
    @(posedge clk);
    if (reset_n && we && waddr != 5'd0) begin
      ma[waddr] = mmerge(ma[waddr], wdata, wstrb);
      if (waddr < 5'd24) mb[waddr] = mmerge(mb[waddr], wdata, wstrb);
    end
    @(negedge clk);
  endtask

  task automatic push_model(string tag);
    exp_t e;
    e.tag   = tag;
    e.a0    = model_rd(1'b0, raddr[4:0], 1'b1);
    e.a1    = model_rd(1'b0, raddr[9:5], 1'b1);
    e.a2    = model_rd(1'b0, raddr[14:10], 1'b1);
    e.adbg  = model_rd(1'b0, dbg_sel, 1'b0);
    e.chk_b = 1'b1;
    e.b0    = model_rd(1'b1, raddr[4:0], 1'b0);
    e.b1    = model_rd(1'b1, raddr[9:5], 1'b0);
    e.bdbg  = model_rd(1'b1, dbg_sel, 1'b0);
    sb_q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check({e.tag, " a_rd0"}, rdata_a[31:0], e.a0);
      check({e.tag, " a_rd1"}, rdata_a[63:32], e.a1);
      check({e.tag, " a_rd2"}, rdata_a[95:64], e.a2);
      check({e.tag, " a_dbg"}, dbg_a, e.adbg);
      if (e.chk_b) begin
        check({e.tag, " b_rd0"}, rdata_b[31:0], e.b0);
        check({e.tag, " b_rd1"}, rdata_b[63:32], e.b1);
        check({e.tag, " b_dbg"}, dbg_b, e.bdbg);
      end
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;

    // rst, we, waddr, wdata, wstrb, ra0, ra1, ra2, dbg, e0, e1, e2, edbg (instance A)
    tbl[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0, 5'd1, 5'd5,
                32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5, 5'd0, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 5'd7, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b1, 5'd5, 32'h12345678, 4'hF, 5'd5, 5'd5, 5'd5, 5'd5,
                32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 5'd5, 5'd5,
                32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 5'd0, 32'h12345678, 4'hF, 5'd0, 5'd0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 5'd7, 32'h11223344, 4'hF, 5'd7, 5'd3, 5'd5, 5'd7,
                32'h11223344, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd7, 5'd7, 5'd7,
                32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7, 5'd7, 5'd7,
                32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
    tbl[10] = '{1'b1, 1'b1, 5'd3, 32'h00000F00, 4'hF, 5'd3, 5'd3, 5'd7, 5'd3,
                32'h00000F00, 32'h00000F00, 32'h11BB33DD, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 5'd3, 5'd3, 5'd3, 5'd3,
                32'h00000F00, 32'h00000F00, 32'h00000F00, 32'h00000F00};
    tbl[12] = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd31, 5'd30, 5'd31,
                32'h00000F00, 32'h0, 32'h0, 32'h0};

    v = tbl[0];
    drive(v);
    @(negedge clk);

    // Directed table on instance A.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      e.tag   = $sformatf("vec%0d", i);
      e.a0    = tbl[i].e0;
      e.a1    = tbl[i].e1;
      e.a2    = tbl[i].e2;
      e.adbg  = tbl[i].edbg;
      e.chk_b = 1'b0;
      e.b0    = 32'h0;
      e.b1    = 32'h0;
      e.bdbg  = 32'h0;
      sb_q.push_back(e);
      score();
      commit_edge();
    end

    // Instance B: bypass disabled, DEPTH=24 out-of-range handling.
    v = '{1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_reset rd0", rdata_b[31:0], 32'h0);
    check("b_reset dbg", dbg_b, 32'h0);
    commit_edge();

    v = '{1'b1, 1'b1, 5'd3, 32'h00000F00, 4'hF, 5'd3, 5'd3, 5'd3, 5'd3,
          32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_nobyp rd0", rdata_b[31:0], 32'h0);
    check("b_nobyp rd1", rdata_b[63:32], 32'h0);
    check("b_nobyp dbg", dbg_b, 32'h0);
    check("a_byp rd0", rdata_a[31:0], 32'h00000F00);
    commit_edge();

    v = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_after rd0", rdata_b[31:0], 32'h00000F00);
    commit_edge();

    v = '{1'b1, 1'b1, 5'd23, 32'hCAFEF00D, 4'hF, 5'd23, 5'd0, 5'd0, 5'd23,
          32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_x23_wr rd0", rdata_b[31:0], 32'h0);
    commit_edge();

    v = '{1'b1, 1'b1, 5'd30, 32'hFFFFFFFF, 4'hF, 5'd30, 5'd23, 5'd0, 5'd30,
          32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_oor_wr rd30", rdata_b[31:0], 32'h0);
    check("b_oor_wr rd23", rdata_b[63:32], 32'hCAFEF00D);
    check("b_oor_wr dbg30", dbg_b, 32'h0);
    commit_edge();

    v = '{1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd30, 5'd23, 5'd0, 5'd23,
          32'h0, 32'h0, 32'h0, 32'h0};
    drive(v);
    #1;
    check("b_oor rd30", rdata_b[31:0], 32'h0);
    check("b_oor rd23", rdata_b[63:32], 32'hCAFEF00D);
    check("b_oor dbg23", dbg_b, 32'hCAFEF00D);
    check("a_in_range rd30", rdata_a[31:0], 32'hFFFFFFFF);
    commit_edge();

    // Random regression against the scoreboard model, both instances.
    for (int c = 0; c < 10000; c++) begin
      v.rst   = ($urandom_range(0, 63) != 0);
      v.we    = ($urandom_range(0, 3) != 0);
      v.waddr = 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.ra0   = ($urandom_range(0, 1) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      v.ra1   = ($urandom_range(0, 3) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      v.ra2   = 5'($urandom_range(0, 31));
      v.dbg   = ($urandom_range(0, 3) == 0) ? v.waddr : 5'($urandom_range(0, 31));
      drive(v);
      push_model($sformatf("rnd%0d", c));
      score();
      commit_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
